// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// multicycle_control_fsm: Moore control unit for the multicycle RV32I datapath.
// Revision 1.0 - initial release.
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       instr_done,
  output logic       illegal_op
);

  localparam bit RESET_STATE_FETCH = 1'b1;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  // FETCH is the only legal reset target; the flag is fixed at 1.
  localparam state_t RESET_STATE = RESET_STATE_FETCH ? S_FETCH : S_FETCH;

  state_t state;
  state_t next_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RESET_STATE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = S_FETCH;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        next_state = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECR;
          OP_I:         next_state = S_EXECI;
          OP_BEQ:       next_state = S_BEQ;
          OP_JAL:       next_state = S_JAL;
          default: begin
            next_state = S_FETCH;
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        next_state = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        next_state = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        instr_done = mem_ready;
        next_state = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b11;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUOp      = 2'b01;
        PCWrite    = Zero;
        instr_done = 1'b1;
      end
      S_JAL: begin
        // Target already sits in ALUOut from DECODE; PC+4 goes to rd in ALUWB.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        next_state = S_ALUWB;
      end
      default: next_state = S_FETCH;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// tb_multicycle_control_fsm: directed bench with an instruction-level expectation model.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal_op;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk(clk), .rst(rst), .op(op), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ImmSrc(ImmSrc), .instr_done(instr_done), .illegal_op(illegal_op)
  );

  // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc,instr_done,illegal_op}
  logic [16:0] dut_vec;
  assign dut_vec = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                    ALUSrcB, ALUOp, ImmSrc, instr_done, illegal_op};

  typedef struct {
    logic [6:0]  op;
    logic        z;
    logic        mr;
    logic [16:0] exp;
  } cyc_t;

  cyc_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic idle_mr  = 1'b1;

  task automatic check(input string name, input logic [16:0] got, input logic [16:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [16:0] pk(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic rw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] aop, input logic [1:0] imm,
                                     input logic dn, input logic il);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, aop, imm, dn, il};
  endfunction

  function automatic void push(input logic [6:0] o, input logic z, input logic mr,
                               input logic [16:0] e);
    cyc_t c;
    c.op = o; c.z = z; c.mr = mr; c.exp = e;
    q.push_back(c);
  endfunction

  // Per-instruction cycle script: fst/mst = memory-not-ready cycles in fetch / data access.
  function automatic void gen(input logic [6:0] o, input logic z, input int fst, input int mst);
    logic [1:0] imm;
    logic       legal;
    imm   = imm_of(o);
    legal = (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
            (o == 7'b0010011) || (o == 7'b1100011) || (o == 7'b1101111);
    for (int i = 0; i <= fst; i++) begin
      logic r;
      r = (i == fst);
      push(o, z, r, pk(r, 0, 0, r, 0, 2'b10, 2'b00, 2'b10, 2'b00, imm, 0, 0));
    end
    push(o, z, idle_mr, pk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, imm, !legal, !legal));
    case (o)
      7'b0000011: begin
        push(o, z, idle_mr, pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, imm, 0, 0));
        for (int i = 0; i <= mst; i++)
          push(o, z, (i == mst), pk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, imm, 0, 0));
        push(o, z, idle_mr, pk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, imm, 1, 0));
      end
      7'b0100011: begin
        push(o, z, idle_mr, pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, imm, 0, 0));
        for (int i = 0; i <= mst; i++)
          push(o, z, (i == mst), pk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, imm, (i == mst), 0));
      end
      7'b0110011, 7'b0010011: begin
        if (o == 7'b0110011)
          push(o, z, idle_mr, pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, imm, 0, 0));
        else
          push(o, z, idle_mr, pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b11, imm, 0, 0));
        push(o, z, idle_mr, pk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, imm, 1, 0));
      end
      7'b1100011:
        push(o, z, idle_mr, pk(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, imm, 1, 0));
      7'b1101111: begin
        push(o, z, idle_mr, pk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, imm, 0, 0));
        push(o, z, idle_mr, pk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, imm, 1, 0));
      end
      default: ;
    endcase
  endfunction

  // Plays up to 'limit' queued cycles; inputs change 1 time unit after posedge, checks at negedge.
  task automatic run(input string name, input int limit, output int last_done, output int n_done,
                     output int n_mw, output int n_rw, output int n_pcw, output int n_ill);
    int k;
    k = 0; last_done = 0; n_done = 0; n_mw = 0; n_rw = 0; n_pcw = 0; n_ill = 0;
    while (q.size() > 0 && k < limit) begin
      cyc_t c;
      c = q.pop_front();
      op = c.op; Zero = c.z; mem_ready = c.mr;
      @(negedge clk);
      check($sformatf("%s cyc%0d", name, k + 1), dut_vec, c.exp);
      k++;
      if (instr_done) begin n_done++; last_done = k; end
      if (MemWrite)   n_mw++;
      if (RegWrite)   n_rw++;
      if (PCWrite)    n_pcw++;
      if (illegal_op) n_ill++;
      @(posedge clk); #1;
    end
    q.delete();
  endtask

  int ld, nd, nmw, nrw, npcw, nill;
  logic [16:0] lit;

  initial begin
    rst = 1'b1; op = 7'b0; Zero = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    lit = {5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
    check("reset_fetch", dut_vec, lit);
    @(posedge clk); #1;
    rst = 1'b0;

    gen(7'b0000011, 0, 0, 0);
    check("lw_model_len", 17'(q.size()), 17'd5);
    run("lw", 100, ld, nd, nmw, nrw, npcw, nill);
    check("lw_latency", 17'(ld), 17'd5);
    check("lw_regwrite", 17'(nrw), 17'd1);

    idle_mr = 1'b0;
    gen(7'b0110011, 0, 0, 0);
    gen(7'b0010011, 0, 0, 0);
    run("r_then_i", 100, ld, nd, nmw, nrw, npcw, nill);
    check("ri_total", 17'(ld), 17'd8);
    check("ri_done", 17'(nd), 17'd2);
    idle_mr = 1'b1;

    gen(7'b1100011, 1, 0, 0);
    run("beq_z1", 100, ld, nd, nmw, nrw, npcw, nill);
    check("beq_z1_latency", 17'(ld), 17'd3);
    check("beq_z1_pcw", 17'(npcw), 17'd2);
    gen(7'b1100011, 0, 0, 0);
    run("beq_z0", 100, ld, nd, nmw, nrw, npcw, nill);
    check("beq_z0_pcw", 17'(npcw), 17'd1);

    gen(7'b1101111, 0, 0, 0);
    run("jal", 100, ld, nd, nmw, nrw, npcw, nill);
    check("jal_latency", 17'(ld), 17'd4);
    check("jal_done", 17'(nd), 17'd1);

    gen(7'b0100011, 0, 0, 3);
    run("sw_stall", 100, ld, nd, nmw, nrw, npcw, nill);
    check("sw_memwrite_cycles", 17'(nmw), 17'd4);
    check("sw_done", 17'(nd), 17'd1);
    check("sw_no_regwrite", 17'(nrw), 17'd0);

    gen(7'b0000011, 0, 2, 1);
    run("lw_stall", 100, ld, nd, nmw, nrw, npcw, nill);
    check("lw_stall_latency", 17'(ld), 17'd8);

    gen(7'b1111111, 0, 0, 0);
    run("illegal", 100, ld, nd, nmw, nrw, npcw, nill);
    check("ill_latency", 17'(ld), 17'd2);
    check("ill_pulse", 17'(nill), 17'd1);
    check("ill_strobes", {nmw[5:0], nrw[5:0], npcw[4:0]}, 17'd1);

    gen(7'b0000011, 0, 0, 0);
    run("lw_after_ill", 100, ld, nd, nmw, nrw, npcw, nill);

    // Park in MEMWRITE with the memory stalled, then reset mid-cycle.
    gen(7'b0100011, 0, 0, 5);
    run("sw_pre_reset", 4, ld, nd, nmw, nrw, npcw, nill);
    mem_ready = 1'b0;
    #2;
    check("memwrite_before_rst", {16'b0, MemWrite}, 17'd1);
    rst = 1'b1;
    #1;
    lit = {5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    check("async_reset_fetch", dut_vec, lit);
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    check("post_reset_fetch", {15'b0, IRWrite, PCWrite}, 17'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
